weight_stage_fifo: RTL

WEIGHT_STAGE_FIFO -- requirements
Module: weight_stage_fifo

---
 rtl/weight_fifo_pkg.sv | 17 +
 rtl/skew_delay_line.sv | 37 +++
 rtl/weight_stage_fifo.sv | 129 ++++++++++++
 3 files changed

// File: rtl/weight_fifo_pkg.sv
// Shared types and width helpers for the weight staging FIFO.
package weight_fifo_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fsmState_e;

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length delay line for one column of weights plus its valid bit.
module skew_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DELAY      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    input  logic [DATA_WIDTH-1:0] inData,
    output logic                  outValid,
    output logic [DATA_WIDTH-1:0] outData
);
    if (DELAY == 0) begin : gPass
        assign outValid = inValid;
        assign outData  = inData;
    end else begin : gDelay
        logic [DELAY-1:0]                 vldPipe;
        logic [DELAY-1:0][DATA_WIDTH-1:0] datPipe;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vldPipe <= '0;
                datPipe <= '0;
            end else begin
                vldPipe[0] <= inValid;
                datPipe[0] <= inData;
                for (int i = 1; i < DELAY; i++) begin
                    vldPipe[i] <= vldPipe[i-1];
                    datPipe[i] <= datPipe[i-1];
                end
            end
        end

        assign outValid = vldPipe[DELAY-1];
        assign outData  = datPipe[DELAY-1];
    end
endmodule

// File: rtl/weight_stage_fifo.sv
// Row FIFO that drains a captured number of weight rows into a systolic array
// with per-column skew, column masking and a completion pulse.
module weight_stage_fifo
    import weight_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_COLS   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] in_data,
    input  logic                           start,
    input  logic [NUM_COLS-1:0]            col_mask,
    output logic [NUM_COLS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_COLS-1:0]            out_valid,
    output logic                           done,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty,
    output logic                           busy
);
    localparam int PW = ptrWidth(DEPTH);
    localparam int CW = cntWidth(DEPTH);
    localparam int FW = $clog2(NUM_COLS + 1);

    logic [NUM_COLS*DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] cnt, rowsLeft, rowsLeftNxt;
    logic [FW-1:0] flushCnt, flushCntNxt;
    fsmState_e     state, stateNxt;
    logic          push, pop;

    logic                           rowVld;
    logic [NUM_COLS*DATA_WIDTH-1:0] rowData;
    logic [NUM_COLS-1:0]                 skVld;
    logic [NUM_COLS-1:0][DATA_WIDTH-1:0] skData;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign in_ready = !full;
    assign count    = cnt;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign push     = in_valid && in_ready;
    assign pop      = (state == DRAIN);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cnt      <= '0;
            state    <= IDLE;
            rowsLeft <= '0;
            flushCnt <= '0;
            rowVld   <= 1'b0;
            rowData  <= '0;
        end else begin
            state    <= stateNxt;
            rowsLeft <= rowsLeftNxt;
            flushCnt <= flushCntNxt;
            rowVld   <= pop;
            if (push) wrPtr <= (wrPtr == PW'(DEPTH-1)) ? '0 : wrPtr + PW'(1);
            if (pop) begin
                rdPtr   <= (rdPtr == PW'(DEPTH-1)) ? '0 : rdPtr + PW'(1);
                rowData <= mem[rdPtr];
            end
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    always_comb begin
        stateNxt    = state;
        rowsLeftNxt = rowsLeft;
        flushCntNxt = flushCnt;
        case (state)
            IDLE: if (start) begin
                if (cnt != '0) begin
                    stateNxt    = DRAIN;
                    rowsLeftNxt = cnt;
                end else begin
                    stateNxt = DONE;
                end
            end
            DRAIN: begin
                rowsLeftNxt = rowsLeft - CW'(1);
                if (rowsLeft == CW'(1)) begin
                    if (NUM_COLS > 1) begin
                        stateNxt    = FLUSH;
                        flushCntNxt = FW'(NUM_COLS - 1);
                    end else begin
                        stateNxt = DONE;
                    end
                end
            end
            FLUSH: begin
                flushCntNxt = flushCnt - FW'(1);
                if (flushCnt == FW'(1)) stateNxt = DONE;
            end
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Column c trails the registered row by c cycles so it meets its array column on time.
    for (genvar c = 0; c < NUM_COLS; c++) begin : gCol
        skew_delay_line #(
            .DATA_WIDTH(DATA_WIDTH),
            .DELAY     (c)
        ) uSkew (
            .clk     (clk),
            .reset   (reset),
            .inValid (rowVld),
            .inData  (rowData[c*DATA_WIDTH +: DATA_WIDTH]),
            .outValid(skVld[c]),
            .outData (skData[c])
        );
        assign out_valid[c] = skVld[c] && !col_mask[c];
        assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = out_valid[c] ? skData[c] : '0;
    end
endmodule
